hbridge_pwm_driver: RTL
=======================

// Module: hbridge_pwm_driver
// PURPOSE
//  Downstream of the line-following controller: consumes its per-side direction codes (IN1/IN2, IN3/IN4) and enables (A/B).
//  Drives the L298-style H-bridge pins with PWM on ENA/ENB, soft-start ramp and dead-time on direction reversal.
//  Two identical channels (A = left motor, B = right motor) share one free-running PWM counter.
// PARAMETERS
//  CNT_W     8     PWM counter width; period = 2**CNT_W clocks
//  DUTY_MAX  200   ceiling on applied duty (counts)
//  RAMP_STEP 4     duty increment per ramp tick
//  RAMP_DIV  1000  clocks per ramp tick
//  DEAD_CYC  500   clocks both bridge inputs held low on a direction change
// PORTS
//  clk     in   1      system clock
//  rst     in   1      asynchronous, active-high reset
//  en_a    in   1      channel A run request (controller OUTA)
//  en_b    in   1      channel B run request (controller OUTB)
//  dir_a   in   2      requested {IN1,IN2} code for A
//  dir_b   in   2      requested {IN3,IN4} code for B
//  duty_a  in   CNT_W  target duty A (counts)
//  duty_b  in   CNT_W  target duty B (counts)
//  hb_in   out  4      {IN1,IN2,IN3,IN4} to bridge
//  pwm_a   out  1      bridge ENA
//  pwm_b   out  1      bridge ENB
//  st_a    out  2      channel A state code
//  st_b    out  2      channel B state code
// BEHAVIOUR
//  Reset: cnt=0, hb_in=0, pwm_a/b=0, cur_duty=0, shadow=0, st=IDLE, dir latches=0; takes effect immediately, asynchronously.
//  Counter: cnt increments every clk and wraps from 2**CNT_W-1 to 0.
//  Duty: tgt = min(duty_x, DUTY_MAX). pwm_x is registered (cnt < shadow_x). shadow_x loads cur_duty_x only when cnt wraps, so PWM never glitches.
//   shadow=0 gives constant low; full scale gives (2**CNT_W-1) high counts per period.
//  Per-channel FSM, state codes IDLE=0, RAMP=1, RUN=2, DEAD=3:
//   IDLE: pwm low, cur_duty=0, hb bits hold last latched dir. On en high: latch dir and go to RAMP the next clk.
//    If the requested dir differs from the latch and the latch is nonzero, go to DEAD instead.
//   RAMP: every RAMP_DIV clks, cur_duty += RAMP_STEP, saturating at tgt. Reaching tgt moves to RUN.
//   RUN: cur_duty tracks tgt. If tgt drops, cur_duty follows immediately (no ramp-down). If tgt rises above cur_duty, return to RAMP.
//   Either RAMP or RUN: dir != latch moves to DEAD next clk.
//   DEAD: hb bits of the channel = 00; pwm forced low immediately (bypasses shadow); cur_duty=0.
//    After exactly DEAD_CYC clks: latch new dir, go to RAMP. A further dir change during DEAD restarts the dead count.
//  Priority: en low beats everything. From any state, go to IDLE next clk; pwm forced low that same clk; dead/ramp counters cleared.
//  Dir codes 00 and 11 are brake codes: passed through like any other, and changes to or from them still incur DEAD.
//  Channels are fully independent; simultaneous events on A and B are handled in parallel.
// CONFIGURATION
//  HBRIDGE_SOFTSTART_EN defined: RAMP behaves as above.
//  Undefined: RAMP state is never entered. IDLE/DEAD go straight to RUN with cur_duty=tgt, and the ramp timer is not built.
// STRUCTURE
//  Package hbridge_pkg: state encoding localparams (IDLE/RAMP/RUN/DEAD) and direction/brake code constants.
//  Sub-module hbridge_pwm_channel: one FSM + ramp/dead timers + shadow compare, instanced twice.
//   The top holds the shared counter and the wrap strobe.
// TESTING (bench params: CNT_W=4, DUTY_MAX=12, RAMP_STEP=4, RAMP_DIV=2, DEAD_CYC=3)
//  1 en_a rises, dir_a=10, duty_a=8 -> st_a=RAMP next clk; cur_duty 0,4,8 at 2-clk spacing; then RUN with pwm_a high 8 of 16 clks.
//  2 duty_a=15 in RUN -> duty saturates at 12; pwm_a high 12 of 16 clks from the next wrap.
//  3 dir_a 10->01 in RUN -> hb_in[3:2]=00 and pwm_a=0 for exactly 3 clks, then hb_in[3:2]=01 and ramp restarts from 0.
//  4 en_a drops during DEAD -> st_a=IDLE next clk, pwm_a=0; channel B waveform undisturbed.
//  5 rst pulsed mid-RUN on both channels -> all outputs 0 and st=IDLE immediately, without waiting for a clk edge.
//  6 macro undefined, en_b rises with duty_b=8 -> st_b=RUN next clk; pwm_b high 8/16 from the first wrap.

Source files
------------

// File: rtl/hbridge_pkg.sv
// Shared types and constants for the H-bridge PWM driver: channel state codes and direction codes.
package hbridge_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRamp = 2'd1,
    StRun  = 2'd2,
    StDead = 2'd3
  } hb_state_e;

  typedef logic [1:0] dir_t;

  localparam dir_t DirBrakeLo = 2'b00;
  localparam dir_t DirRev     = 2'b01;
  localparam dir_t DirFwd     = 2'b10;
  localparam dir_t DirBrakeHi = 2'b11;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/hbridge_pwm_driver_if.sv
// Controller-to-driver bundle: per-side run requests, direction codes and target duties,
// plus the bridge pin and status outputs.
interface hbridge_pwm_driver_if #(
  parameter int unsigned CNT_W = 8
);
  import hbridge_pkg::*;

  logic             en_a;
  logic             en_b;
  dir_t             dir_a;
  dir_t             dir_b;
  logic [CNT_W-1:0] duty_a;
  logic [CNT_W-1:0] duty_b;
  logic [3:0]       hb_in;
  logic             pwm_a;
  logic             pwm_b;
  logic [1:0]       st_a;
  logic [1:0]       st_b;

  modport master (
    output en_a, en_b, dir_a, dir_b, duty_a, duty_b,
    input  hb_in, pwm_a, pwm_b, st_a, st_b
  );

  modport slave (
    input  en_a, en_b, dir_a, dir_b, duty_a, duty_b,
    output hb_in, pwm_a, pwm_b, st_a, st_b
  );

endinterface

// File: rtl/hbridge_pwm_channel.sv
// One motor channel: run/ramp/dead FSM, wrap-synchronous duty shadow and registered PWM compare.
// Soft-start ramp is built only when HBRIDGE_SOFTSTART_EN is defined.
module hbridge_pwm_channel
  import hbridge_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DUTY_MAX  = 200,
  parameter int unsigned RAMP_STEP = 4,
  parameter int unsigned RAMP_DIV  = 1000,
  parameter int unsigned DEAD_CYC  = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  dir_t             dir_i,
  input  logic [CNT_W-1:0] duty_i,
  input  logic [CNT_W-1:0] cnt_nxt_i,
  input  logic             wrap_i,
  output logic [1:0]       hb_o,
  output logic             pwm_o,
  output logic [1:0]       st_o
);

  localparam int unsigned      FullScale = (2 ** CNT_W) - 1;
  localparam logic [CNT_W-1:0] DutyCap   = CNT_W'(min_u(DUTY_MAX, FullScale));
  localparam int unsigned      DeadW     = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

  hb_state_e        st_q, st_d;
  dir_t             dir_q, dir_d, pend_q, pend_d;
  logic [CNT_W-1:0] cur_q, cur_d, shadow_q, shadow_d, tgt;
  logic             pwm_q, pwm_d;
  logic [DeadW-1:0] dead_q, dead_d;

  assign tgt = (duty_i > DutyCap) ? DutyCap : duty_i;

`ifdef HBRIDGE_SOFTSTART_EN
  localparam int unsigned RampW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  logic [RampW-1:0] ramp_q, ramp_d;
  logic [CNT_W:0]   ramp_sum;

  assign ramp_sum = {1'b0, cur_q} + (CNT_W + 1)'(RAMP_STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ramp_q <= '0;
    else     ramp_q <= ramp_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= StIdle;
      dir_q    <= DirBrakeLo;
      pend_q   <= DirBrakeLo;
      cur_q    <= '0;
      shadow_q <= '0;
      pwm_q    <= 1'b0;
      dead_q   <= '0;
    end else begin
      st_q     <= st_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      cur_q    <= cur_d;
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
      dead_q   <= dead_d;
    end
  end

  // Compare against the post-edge counter so pwm_q lines up with the visible count.
  assign shadow_d = wrap_i ? cur_q : shadow_q;
  assign pwm_d    = (cnt_nxt_i < shadow_d);

  always_comb begin
    st_d   = st_q;
    dir_d  = dir_q;
    pend_d = pend_q;
    cur_d  = cur_q;
    dead_d = dead_q;
`ifdef HBRIDGE_SOFTSTART_EN
    ramp_d = ramp_q;
`endif
    if (!en_i) begin
      st_d   = StIdle;
      cur_d  = '0;
      dead_d = '0;
`ifdef HBRIDGE_SOFTSTART_EN
      ramp_d = '0;
`endif
    end else begin
      unique case (st_q)
        StIdle: begin
          dead_d = '0;
          if (dir_i != dir_q && dir_q != DirBrakeLo) begin
            st_d   = StDead;
            pend_d = dir_i;
          end else begin
            dir_d = dir_i;
`ifdef HBRIDGE_SOFTSTART_EN
            st_d   = StRamp;
            ramp_d = '0;
`else
            st_d  = StRun;
            cur_d = tgt;
`endif
          end
        end
`ifdef HBRIDGE_SOFTSTART_EN
        StRamp: begin
          if (dir_i != dir_q) begin
            st_d   = StDead;
            pend_d = dir_i;
            cur_d  = '0;
            dead_d = '0;
            ramp_d = '0;
          end else if (cur_q >= tgt) begin
            st_d   = StRun;
            cur_d  = tgt;
            ramp_d = '0;
          end else if (ramp_q == RampW'(RAMP_DIV - 1)) begin
            ramp_d = '0;
            if (ramp_sum >= {1'b0, tgt}) begin
              st_d  = StRun;
              cur_d = tgt;
            end else begin
              cur_d = ramp_sum[CNT_W-1:0];
            end
          end else begin
            ramp_d = ramp_q + RampW'(1);
          end
        end
`endif
        StRun: begin
          if (dir_i != dir_q) begin
            st_d   = StDead;
            pend_d = dir_i;
            cur_d  = '0;
            dead_d = '0;
`ifdef HBRIDGE_SOFTSTART_EN
          end else if (tgt > cur_q) begin
            st_d   = StRamp;
            ramp_d = '0;
`endif
          end else begin
            cur_d = tgt;
          end
        end
        StDead: begin
          cur_d = '0;
          if (dir_i != pend_q) begin
            pend_d = dir_i;
            dead_d = '0;
          end else if (dead_q == DeadW'(DEAD_CYC - 1)) begin
            dir_d  = pend_q;
            dead_d = '0;
`ifdef HBRIDGE_SOFTSTART_EN
            st_d   = StRamp;
            ramp_d = '0;
`else
            st_d  = StRun;
            cur_d = tgt;
`endif
          end else begin
            dead_d = dead_q + DeadW'(1);
          end
        end
        default: st_d = StIdle;
      endcase
    end
  end

  // en and DEAD gate the pin combinationally so the bridge shuts off without waiting a wrap.
  always_comb begin
    hb_o  = (st_q == StDead) ? DirBrakeLo : dir_q;
    pwm_o = pwm_q && en_i && (st_q == StRamp || st_q == StRun);
    st_o  = st_q;
  end

endmodule

// File: rtl/hbridge_pwm_driver.sv
// Dual-channel L298-style H-bridge driver: shared free-running PWM counter, two channel instances.
// Optional soft-start ramp enabled by defining HBRIDGE_SOFTSTART_EN.
module hbridge_pwm_driver
  import hbridge_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DUTY_MAX  = 200,
  parameter int unsigned RAMP_STEP = 4,
  parameter int unsigned RAMP_DIV  = 1000,
  parameter int unsigned DEAD_CYC  = 500
) (
  input logic                 clk,
  input logic                 rst,
  hbridge_pwm_driver_if.slave bus
);

  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             wrap;

  assign cnt_nxt = cnt_q + 1'b1;
  assign wrap    = &cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_nxt;
  end

  hbridge_pwm_channel #(
    .CNT_W    (CNT_W),
    .DUTY_MAX (DUTY_MAX),
    .RAMP_STEP(RAMP_STEP),
    .RAMP_DIV (RAMP_DIV),
    .DEAD_CYC (DEAD_CYC)
  ) u_ch_a (
    .clk      (clk),
    .rst      (rst),
    .en_i     (bus.en_a),
    .dir_i    (bus.dir_a),
    .duty_i   (bus.duty_a),
    .cnt_nxt_i(cnt_nxt),
    .wrap_i   (wrap),
    .hb_o     (bus.hb_in[3:2]),
    .pwm_o    (bus.pwm_a),
    .st_o     (bus.st_a)
  );

  hbridge_pwm_channel #(
    .CNT_W    (CNT_W),
    .DUTY_MAX (DUTY_MAX),
    .RAMP_STEP(RAMP_STEP),
    .RAMP_DIV (RAMP_DIV),
    .DEAD_CYC (DEAD_CYC)
  ) u_ch_b (
    .clk      (clk),
    .rst      (rst),
    .en_i     (bus.en_b),
    .dir_i    (bus.dir_b),
    .duty_i   (bus.duty_b),
    .cnt_nxt_i(cnt_nxt),
    .wrap_i   (wrap),
    .hb_o     (bus.hb_in[1:0]),
    .pwm_o    (bus.pwm_b),
    .st_o     (bus.st_b)
  );

endmodule
